// File: rtl/if_id_stage_reg.sv
// ----------------------------------------------------------------------------
// if_id_stage_reg
//
// IF/ID pipeline register of the 5-stage MIPS core. Captures the fetched
// instruction, its PC and any fetch exception code each cycle. It applies the
// hazard-unit stall, exception-handler flush and ERET squash, and it tags
// instructions that sit in a branch delay slot so CP0 can form the EPC.
//
// Ports
//   clk          in   1   core clock, all state updates on posedge
//   Reset        in   1   synchronous, active-high reset
//   stall_id     in   1   hold IF/ID contents
//   flush        in   1   exception/interrupt entry: squash incoming instr
//   eret_id      in   1   ERET in ID: squash the instr fetched behind it
//   id_is_branch in   1   branch/jump decoded in ID this cycle
//   instr_i      in   32  fetched instruction
//   pc_i         in   32  PC of instr_i
//   exc_i        in   5   fetch exception code (ADEL or NO_EXC_CODE)
//   instr_d      out  32  instruction to decode
//   pc_d         out  32  PC of instr_d
//   pc8_d        out  32  pc_d + 8 link address (combinational)
//   exc_d        out  5   exception code carried with instr_d
//   bd_d         out  1   instr_d sits in a branch delay slot
//   valid_d      out  1   0 = bubble, 1 = real instruction
//
// Optional feature (macro IF_ID_PERF_EN):
//   stall_cnt    out  32  cycles spent stalled (saturating)
//   bubble_cnt   out  32  bubbles inserted by flush or ERET squash (saturating)
// ----------------------------------------------------------------------------
module if_id_stage_reg #(
  parameter logic [31:0] PC_RESET    = 32'h0000_3000,
  parameter logic [4:0]  NO_EXC_CODE = 5'd0,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        stall_id,
  input  logic        flush,
  input  logic        eret_id,
  input  logic        id_is_branch,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [4:0]  exc_i,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [4:0]  exc_d,
  output logic        bd_d,
  output logic        valid_d
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  // Bubble insertion: a flush always wins over a stall, while an ERET squash
  // only takes effect once the stall has released.
  logic insert_bubble;
  logic hold;

  assign insert_bubble = flush | (eret_id & ~stall_id);
  assign hold          = stall_id & ~flush;

  always_ff @(posedge clk) begin
    if (Reset) begin
      instr_d <= NOP_INSTR;
      pc_d    <= PC_RESET;
      exc_d   <= NO_EXC_CODE;
      bd_d    <= 1'b0;
      valid_d <= 1'b0;
    end else if (insert_bubble) begin
      // pc_d still follows pc_i so an EPC taken from a bubble stays meaningful.
      instr_d <= NOP_INSTR;
      pc_d    <= pc_i;
      exc_d   <= NO_EXC_CODE;
      bd_d    <= 1'b0;
      valid_d <= 1'b0;
    end else if (!hold) begin
      // A faulting fetch must never reach decode as a real opcode; the
      // exception code travels on untouched, even for a delay-slot instr.
      instr_d <= (exc_i != NO_EXC_CODE) ? NOP_INSTR : instr_i;
      pc_d    <= pc_i;
      exc_d   <= exc_i;
      // valid_d is the ID-stage valid of the branch currently in decode; a
      // branch held in ID across a stall still marks the instr that follows.
      bd_d    <= id_is_branch & valid_d;
      valid_d <= 1'b1;
    end
  end

  assign pc8_d = pc_d + 32'd8;

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (hold && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (insert_bubble && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_if_id_stage_reg
//
// Directed, self-checking bench for if_id_stage_reg. Each scenario task drives
// its own vectors and compares outputs against hand-computed values. Outputs
// are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_if_id_stage_reg;

  logic        clk = 1'b0;
  logic        Reset;
  logic        stall_id;
  logic        flush;
  logic        eret_id;
  logic        id_is_branch;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [4:0]  exc_i;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic [4:0]  exc_d;
  logic        bd_d;
  logic        valid_d;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] exp_stall_cnt;
  logic [31:0] exp_bubble_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  if_id_stage_reg dut (
    .clk          (clk),
    .Reset        (Reset),
    .stall_id     (stall_id),
    .flush        (flush),
    .eret_id      (eret_id),
    .id_is_branch (id_is_branch),
    .instr_i      (instr_i),
    .pc_i         (pc_i),
    .exc_i        (exc_i),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc8_d        (pc8_d),
    .exc_d        (exc_d),
    .bd_d         (bd_d),
    .valid_d      (valid_d)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock edge; the perf model counts from the inputs being applied.
  task automatic tick();
`ifdef IF_ID_PERF_EN
    if (Reset) begin
      exp_stall_cnt  = 32'd0;
      exp_bubble_cnt = 32'd0;
    end else begin
      if (stall_id && !flush) exp_stall_cnt = exp_stall_cnt + 32'd1;
      if (flush || (eret_id && !stall_id)) exp_bubble_cnt = exp_bubble_cnt + 32'd1;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; stall_id = 1'b0; flush = 1'b0; eret_id = 1'b0; id_is_branch = 1'b0;
    instr_i = 32'hDEAD_BEEF; pc_i = 32'h1234_5678; exc_i = 5'd4;
    tick(); tick();
    n_cmp++; if (instr_d !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr got %h want %h", instr_d, 32'h0); end
    n_cmp++; if (pc_d !== 32'h3000) begin n_fail++; $display("[TB] FAIL reset_pc got %h want %h", pc_d, 32'h3000); end
    n_cmp++; if (exc_d !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_exc got %h want %h", exc_d, 5'd0); end
    n_cmp++; if (valid_d !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", valid_d); end
    n_cmp++; if (bd_d !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bd got %b want 0", bd_d); end
    n_cmp++; if (pc8_d !== 32'h3008) begin n_fail++; $display("[TB] FAIL reset_pc8 got %h want %h", pc8_d, 32'h3008); end
`ifdef IF_ID_PERF_EN
    n_cmp++; if (stall_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    n_cmp++; if (bubble_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_bubble_cnt got %0d want 0", bubble_cnt); end
`endif
  endtask

  task automatic test_load();
    Reset = 1'b0;
    instr_i = 32'h2408_0005; pc_i = 32'h3004; exc_i = 5'd0;
    tick();
    n_cmp++; if (instr_d !== 32'h2408_0005) begin n_fail++; $display("[TB] FAIL load_instr got %h want %h", instr_d, 32'h2408_0005); end
    n_cmp++; if (pc_d !== 32'h3004) begin n_fail++; $display("[TB] FAIL load_pc got %h want %h", pc_d, 32'h3004); end
    n_cmp++; if (pc8_d !== 32'h300C) begin n_fail++; $display("[TB] FAIL load_pc8 got %h want %h", pc8_d, 32'h300C); end
    n_cmp++; if (valid_d !== 1'b1) begin n_fail++; $display("[TB] FAIL load_valid got %b want 1", valid_d); end
    n_cmp++; if (bd_d !== 1'b0) begin n_fail++; $display("[TB] FAIL load_bd got %b want 0", bd_d); end
    n_cmp++; if (exc_d !== 5'd0) begin n_fail++; $display("[TB] FAIL load_exc got %h want 0", exc_d); end
    // New fetch data between edges must not leak through to decode.
    instr_i = 32'h1000_0003; pc_i = 32'h3008;
    #2;
    n_cmp++; if (instr_d !== 32'h2408_0005) begin n_fail++; $display("[TB] FAIL load_no_comb_path got %h want %h", instr_d, 32'h2408_0005); end
  endtask

  task automatic test_stall_bd();
    // beq at 3008 enters ID, then is held there by a 3-cycle stall.
    tick();
    id_is_branch = 1'b1; stall_id = 1'b1;
    instr_i = 32'h2009_0001; pc_i = 32'h300C;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (instr_d !== 32'h1000_0003) begin n_fail++; $display("[TB] FAIL stall_instr[%0d] got %h want %h", i, instr_d, 32'h1000_0003); end
      n_cmp++; if (pc_d !== 32'h3008) begin n_fail++; $display("[TB] FAIL stall_pc[%0d] got %h want %h", i, pc_d, 32'h3008); end
      n_cmp++; if (bd_d !== 1'b0 || valid_d !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_bd_valid[%0d] got %b%b want 01", i, bd_d, valid_d); end
    end
    stall_id = 1'b0;
    tick();
    n_cmp++; if (instr_d !== 32'h2009_0001) begin n_fail++; $display("[TB] FAIL release_instr got %h want %h", instr_d, 32'h2009_0001); end
    n_cmp++; if (pc_d !== 32'h300C) begin n_fail++; $display("[TB] FAIL release_pc got %h want %h", pc_d, 32'h300C); end
    n_cmp++; if (bd_d !== 1'b1) begin n_fail++; $display("[TB] FAIL release_bd got %b want 1", bd_d); end
`ifdef IF_ID_PERF_EN
    n_cmp++; if (stall_cnt !== exp_stall_cnt) begin n_fail++; $display("[TB] FAIL stall_cnt got %0d want %0d", stall_cnt, exp_stall_cnt); end
`endif
  endtask

  task automatic test_fetch_exc();
    // id_is_branch stays high with a valid ID instr: BD and ADEL coexist.
    instr_i = 32'h8C08_0000; pc_i = 32'h3002; exc_i = 5'd4;
    tick();
    n_cmp++; if (instr_d !== 32'h0) begin n_fail++; $display("[TB] FAIL exc_instr got %h want 0", instr_d); end
    n_cmp++; if (exc_d !== 5'd4) begin n_fail++; $display("[TB] FAIL exc_code got %h want %h", exc_d, 5'd4); end
    n_cmp++; if (pc_d !== 32'h3002) begin n_fail++; $display("[TB] FAIL exc_pc got %h want %h", pc_d, 32'h3002); end
    n_cmp++; if (valid_d !== 1'b1) begin n_fail++; $display("[TB] FAIL exc_valid got %b want 1", valid_d); end
    n_cmp++; if (bd_d !== 1'b1) begin n_fail++; $display("[TB] FAIL exc_bd got %b want 1", bd_d); end
  endtask

  task automatic test_flush();
    flush = 1'b1; stall_id = 1'b1;
    instr_i = 32'h0123_4567; pc_i = 32'h4180; exc_i = 5'd4;
    tick();
    flush = 1'b0; stall_id = 1'b0; id_is_branch = 1'b0; exc_i = 5'd0;
    n_cmp++; if (instr_d !== 32'h0) begin n_fail++; $display("[TB] FAIL flush_instr got %h want 0", instr_d); end
    n_cmp++; if (valid_d !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid got %b want 0", valid_d); end
    n_cmp++; if (pc_d !== 32'h4180) begin n_fail++; $display("[TB] FAIL flush_pc got %h want %h", pc_d, 32'h4180); end
    n_cmp++; if (exc_d !== 5'd0 || bd_d !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_exc_bd got %h/%b want 0/0", exc_d, bd_d); end
`ifdef IF_ID_PERF_EN
    n_cmp++; if (bubble_cnt !== exp_bubble_cnt) begin n_fail++; $display("[TB] FAIL flush_bubble_cnt got %0d want %0d", bubble_cnt, exp_bubble_cnt); end
    n_cmp++; if (stall_cnt !== exp_stall_cnt) begin n_fail++; $display("[TB] FAIL flush_stall_cnt got %0d want %0d", stall_cnt, exp_stall_cnt); end
`endif
  endtask

  task automatic test_eret();
    instr_i = 32'h4200_0018; pc_i = 32'h4184;
    tick();
    eret_id = 1'b1; instr_i = 32'h2402_0001; pc_i = 32'h4188;
    tick();
    n_cmp++; if (valid_d !== 1'b0 || instr_d !== 32'h0) begin n_fail++; $display("[TB] FAIL eret_bubble got v=%b i=%h want v=0 i=0", valid_d, instr_d); end
    n_cmp++; if (pc_d !== 32'h4188) begin n_fail++; $display("[TB] FAIL eret_pc got %h want %h", pc_d, 32'h4188); end
    eret_id = 1'b0; instr_i = 32'h0000_ABCD; pc_i = 32'h418C;
    tick();
    eret_id = 1'b1; stall_id = 1'b1; instr_i = 32'h1111_1111; pc_i = 32'h4190;
    tick();
    n_cmp++; if (instr_d !== 32'h0000_ABCD || pc_d !== 32'h418C) begin n_fail++; $display("[TB] FAIL eret_stall_hold got %h@%h want %h@%h", instr_d, pc_d, 32'h0000_ABCD, 32'h418C); end
    n_cmp++; if (valid_d !== 1'b1) begin n_fail++; $display("[TB] FAIL eret_stall_valid got %b want 1", valid_d); end
    eret_id = 1'b0; stall_id = 1'b0;
`ifdef IF_ID_PERF_EN
    n_cmp++; if (bubble_cnt !== exp_bubble_cnt) begin n_fail++; $display("[TB] FAIL eret_bubble_cnt got %0d want %0d", bubble_cnt, exp_bubble_cnt); end
`endif
  endtask

  task automatic test_pc_wrap();
    instr_i = 32'h0C00_0000; pc_i = 32'hFFFF_FFFC;
    tick();
    n_cmp++; if (pc8_d !== 32'h0000_0004) begin n_fail++; $display("[TB] FAIL pc8_wrap got %h want %h", pc8_d, 32'h4); end
  endtask

  task automatic test_reset_mid_stall();
    stall_id = 1'b1; Reset = 1'b1;
    tick();
    n_cmp++; if (pc_d !== 32'h3000 || valid_d !== 1'b0 || instr_d !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mid_stall got %h/%b/%h want 3000/0/0", pc_d, valid_d, instr_d); end
    stall_id = 1'b0; Reset = 1'b0; instr_i = 32'h2408_0005; pc_i = 32'h3004;
    tick();
    flush = 1'b1; Reset = 1'b1;
    tick();
    n_cmp++; if (pc_d !== 32'h3000 || valid_d !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mid_flush got %h/%b want 3000/0", pc_d, valid_d); end
`ifdef IF_ID_PERF_EN
    n_cmp++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
`endif
    flush = 1'b0; Reset = 1'b0;
  endtask

  initial begin
`ifdef IF_ID_PERF_EN
    exp_stall_cnt  = 32'd0;
    exp_bubble_cnt = 32'd0;
`endif
    test_reset();
    test_load();
    test_stall_bd();
    test_fetch_exc();
    test_flush();
    test_eret();
    test_pc_wrap();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
